seg_adder: RTL and testbench
============================

# seg_adder

Parametrised multi-cycle segmented adder for the datapath. It adds two WIDTH-bit operands one SEG-bit segment per clock, least-significant segment first, holding the inter-segment carry in a register. Operands enter and results leave through valid/ready handshakes, so the ALU can trade area for latency by choosing SEG. The result includes carry-out and signed overflow, with an optional subtract mode.

## Interface
- WIDTH, 16: operand and result width. Must be a positive multiple of SEG.
- SEG, 4: bits added per cycle.
- NSEG is derived, not overridable: NSEG = WIDTH/SEG segments.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, or borrow-in when sub=1.
- sub  in  1  1 selects A − B (see Configuration).
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

## Operation
- **States:** IDLE, RUN, DONE. Reset places the block in IDLE.
- **in_ready:** equals (state==IDLE). It is combinational from state only.
- **IDLE:**
  - When in_valid is high, the block captures a and b into internal registers. If sub is in effect, it captures ~b instead of b.
  - Carry register is loaded with cin XOR sub.
  - Segment counter is set to 0.
  - State moves to RUN.
- **RUN, each cycle:**
  - Segment k computes {c, s} = a[k] + b'[k] + carry.
  - s is written into result bits [k*SEG +: SEG], and carry is set to c.
  - On the last segment (k==NSEG-1), cout is latched from c. ovf is latched as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). State moves to DONE.
  - Otherwise k increments.
- **DONE:**
  - out_valid=1.
  - sum, cout and ovf hold stable until out_ready is high at a clock edge. On that edge the state moves to IDLE.
  - New operands are not accepted in DONE.
- **Output validity:** sum, cout and ovf are meaningful only while out_valid=1.
- **Subtract semantics:**
  - sub=1, cin=0 gives A − B.
  - sub=1, cin=1 gives A − B − 1.
  - cout is the raw carry, so cout=0 means a borrow occurred.
- **NSEG=1 (SEG==WIDTH):** the operation completes in a single RUN cycle.

## Timing
- **Reset values (asynchronous):** state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0, counter=0.
- **Latency:** operands are accepted on edge E0. out_valid rises after edge E0+NSEG.
- **Handshake:** the earliest result transfer is at edge E0+NSEG+1. in_ready rises after that transfer, and the next accept is at E0+NSEG+2 at the earliest.
- **Throughput:** one operation per NSEG+2 cycles when there is no backpressure.
- **Input stability:** a, b, cin and sub are sampled only on the accept edge. Changes at any other time have no effect.
- **Backpressure:** while out_ready=0 in DONE, all outputs hold and in_ready stays 0, for any number of cycles.
- **Reset mid-operation:** asserting rst in RUN or DONE immediately forces the reset values. The in-flight operation is discarded, with no partial result and no out_valid.
- **Simultaneous events:** in_valid and out_ready are never both effective in the same state, so no simultaneous-event conflict exists.

## Configuration
- Macro: SEG_ADDER_SUB_EN.
- **Defined:** sub behaves as described: b is inverted and carry-in becomes cin XOR sub.
- **Not defined:**
  - The sub port remains in the port list but is ignored and treated as 0.
  - No inverter is built on b.
  - The block computes A + B + cin only.

## Test plan
Benches run with WIDTH=16, SEG=4 unless stated otherwise.
- a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry propagates across all 4 segments). Separately, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- With SEG_ADDER_SUB_EN defined, sub=1:
  - a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - Without the macro, sub=1 with a=0x0005, b=0x0007 -> sum=0x000C.
- Backpressure: out_ready held 0 for 3 cycles after out_valid -> sum, cout, ovf and out_valid stable, in_ready=0; transfer on the first out_ready=1 edge, in_ready=1 on the following cycle.
- Assert rst for one cycle during the second RUN cycle -> out_valid=0, sum=0, in_ready=1 immediately; a fresh operation 0x0001+0x0001 afterwards returns 0x0002.
- WIDTH=16, SEG=16: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0; out_valid 1 cycle after the accept edge.

Source files
------------

// File: rtl/seg_adder.sv
// Multi-cycle segmented adder: adds WIDTH-bit operands SEG bits per clock, LSB segment first.
// Optional subtract mode is built only when SEG_ADDER_SUB_EN is defined.
module seg_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG:0]     seg_full;
  logic             last;
  logic             ovf_next;

`ifdef SEG_ADDER_SUB_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = cin ^ sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = b;
  assign cin_in     = cin;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == CW'(NSEG - 1));

  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (cnt == CW'(i)) begin
        seg_a = a_q[i*SEG +: SEG];
        seg_b = b_q[i*SEG +: SEG];
      end
    end
    seg_full = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry};
    // Carry into the MSB equals a^b^s at that bit, so overflow folds to one XOR chain.
    ovf_next = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_full[SEG-1] ^ seg_full[SEG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NSEG; i++) begin
            if (cnt == CW'(i)) sum[i*SEG +: SEG] <= seg_full[SEG-1:0];
          end
          carry <= seg_full[SEG];
          if (last) begin
            cout  <= seg_full[SEG];
            ovf   <= ovf_next;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_adder.sv
// Directed bench for seg_adder: WIDTH=16 with SEG=4 (main instance) and SEG=16 (single-segment instance).
module tb_seg_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [15:0] sum1;
  logic        cout1;
  logic        ovf1;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [17:0] exp_q[$];

  seg_adder #(.WIDTH(16), .SEG(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  seg_adder #(.WIDTH(16), .SEG(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input logic [15:0] s, input logic c, input logic o);
    exp_q.push_back({c, o, s});
  endtask

  // Drive one operation on the SEG=4 instance, hold out_ready low for `hold`
  // cycles once the result appears, then complete the transfer.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv, input int hold);
    logic [17:0] e;
    int lat;
    e = exp_q.pop_front();
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(sum), 32'(e[15:0]));
    check({tag, " cout"}, 32'(cout), 32'(e[17]));
    check({tag, " ovf"}, 32'(ovf), 32'(e[16]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold result"}, 32'({cout, ovf, sum}), 32'(e));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout_ovf", 32'({cout, ovf}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    expect_op(16'h2345, 1'b0, 1'b0); run_op("add basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    expect_op(16'h0000, 1'b1, 1'b0); run_op("carry chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    expect_op(16'h8000, 1'b0, 1'b1); run_op("pos ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    expect_op(16'h0000, 1'b1, 1'b1); run_op("neg ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    expect_op(16'h0101, 1'b0, 1'b0); run_op("cin add", 16'h00FF, 16'h0001, 1'b1, 1'b0, 0);
`ifdef SEG_ADDER_SUB_EN
    expect_op(16'hFFFE, 1'b0, 1'b0); run_op("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    expect_op(16'h7FFF, 1'b1, 1'b1); run_op("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    expect_op(16'h0001, 1'b1, 1'b0); run_op("sub cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 0);
`else
    expect_op(16'h000C, 1'b0, 1'b0); run_op("sub ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    expect_op(16'h8001, 1'b0, 1'b0); run_op("sub ignored2", 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    expect_op(16'h0009, 1'b0, 1'b0); run_op("sub ignored cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 0);
`endif
    expect_op(16'h5555, 1'b0, 1'b0); run_op("backpressure", 16'h1234, 16'h4321, 1'b0, 1'b0, 3);

    // reset asserted during the second RUN cycle
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst sum", 32'(sum), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst no result", 32'(out_valid), 32'd0);
    end
    expect_op(16'h0002, 1'b0, 1'b0); run_op("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    // single-segment instance
    check("seg16 in_ready", 32'(in_ready1), 32'd1);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1; in_valid1 = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("seg16 latency", 32'(lat), 32'd1);
    check("seg16 sum", 32'(sum1), 32'h0000FFFF);
    check("seg16 cout", 32'(cout1), 32'd1);
    check("seg16 ovf", 32'(ovf1), 32'd0);
    out_ready1 = 1'b1;
    @(posedge clk); #1; out_ready1 = 1'b0;
    check("seg16 in_ready back", 32'(in_ready1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
